// File: rtl/bb_mem_bridge_pkg.sv
// Shared FSM state encoding and write-buffer sizing constants for bb_mem_bridge.
// Supplies the global DATA_WIDTH define when the surrounding build does not.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package bb_mem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_DRAIN   = 2'd3
    } bb_state_e;

    localparam int BB_BRIDGE_WBUF_DEPTH = 4;
    localparam int BB_BRIDGE_WBUF_MIN   = 2;
    localparam int BB_BRIDGE_WBUF_MAX   = 16;

endpackage

// File: rtl/bb_mem_bridge_wbuf.sv
// bb_wbuf: posted-write FIFO with a per-entry address compare vector and
// youngest-match data lookup. DEPTH must be a power of two.
module bb_wbuf
    import bb_mem_bridge_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = BB_BRIDGE_WBUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DW-1:0]    push_addr,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    output logic [DW-1:0]    head_addr,
    output logic [DW-1:0]    head_data,
    output logic             full,
    output logic             empty,
    input  logic [DW-1:0]    chk_addr,
    output logic [DEPTH-1:0] match_vec,
    output logic [DW-1:0]    fwd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][DW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CW-1:0]            cnt;
    logic [DEPTH-1:0]         live;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= push_addr;
                data_q[wr_ptr] <= push_data;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    // An entry is live when its distance from the head is below the count.
    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_ent
            logic [AW-1:0] age;
            assign age          = AW'(i) - rd_ptr;
            assign live[i]      = (CW'(age) < cnt);
            assign match_vec[i] = live[i] && (addr_q[i] == chk_addr);
        end
    endgenerate

    // Walk oldest to youngest so the last hit seen is the youngest.
    always_comb begin
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_vec[rd_ptr + AW'(k)])
                fwd_data = data_q[rd_ptr + AW'(k)];
        end
    end

    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);

endmodule

// File: rtl/bb_mem_bridge.sv
// bb_mem_bridge: core-to-external memory bridge with posted writes and one outstanding read.
// Optional macro BB_BRIDGE_FWD_EN: reads hitting buffered writes are served from the buffer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module bb_mem_bridge
    import bb_mem_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int WBUF_DEPTH = BB_BRIDGE_WBUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_r_en,
    input  logic [DATA_WIDTH-1:0] mem_r_addr,
    input  logic                  mem_w_en,
    input  logic [DATA_WIDTH-1:0] mem_w_addr,
    input  logic [DATA_WIDTH-1:0] mem_w_data,
    output logic [DATA_WIDTH-1:0] mem_r_data,
    output logic                  mem_r_valid,
    output logic                  mem_busy,
    output logic                  ext_req,
    output logic                  ext_we,
    output logic [DATA_WIDTH-1:0] ext_addr,
    output logic [DATA_WIDTH-1:0] ext_wdata,
    input  logic                  ext_gnt,
    input  logic                  ext_rvalid,
    input  logic [DATA_WIDTH-1:0] ext_rdata
);

    bb_state_e             state;
    logic                  rd_pend;
    logic [DATA_WIDTH-1:0] rd_addr;
    logic                  ext_req_q;
    logic                  r_valid_q;

    logic [DATA_WIDTH-1:0] chk_addr;
    logic [DATA_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [DATA_WIDTH-1:0] fwd_val;
    logic [WBUF_DEPTH-1:0] match_vec;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  rd_busy;
    logic                  busy_c;
    logic                  accept;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  same_addr;
    logic                  hazard;
    logic                  fwd_now;

    // A pending read (drain wait or issue slot) blocks all new core requests.
    assign rd_busy   = (state == ST_RD_REQ) || (state == ST_RD_WAIT) || rd_pend;
    assign busy_c    = (full && mem_w_en) || rd_busy;
    assign accept    = (mem_r_en || mem_w_en) && !busy_c && !rst_n;
    assign wr_acc    = accept && mem_w_en;
    assign rd_acc    = accept && mem_r_en;
    assign pop       = (state == ST_DRAIN) && ext_gnt;

    assign chk_addr  = rd_pend ? rd_addr : mem_r_addr;
    assign hazard    = |match_vec;
    assign same_addr = wr_acc && (mem_w_addr == mem_r_addr);
    assign fwd_val   = same_addr ? mem_w_data : fwd_data;

`ifdef BB_BRIDGE_FWD_EN
    assign fwd_now = rd_acc && (hazard || same_addr);
`else
    assign fwd_now = 1'b0;
`endif

    assign mem_busy    = busy_c && !rst_n;
    assign ext_req     = ext_req_q && !rst_n;
    assign mem_r_valid = r_valid_q && !rst_n;

    bb_wbuf #(
        .DW    (DATA_WIDTH),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_acc),
        .push_addr (mem_w_addr),
        .push_data (mem_w_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .chk_addr  (chk_addr),
        .match_vec (match_vec),
        .fwd_data  (fwd_data)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            rd_pend    <= 1'b0;
            rd_addr    <= '0;
            ext_req_q  <= 1'b0;
            ext_we     <= 1'b0;
            ext_addr   <= '0;
            ext_wdata  <= '0;
            r_valid_q  <= 1'b0;
            mem_r_data <= '0;
        end else begin
            r_valid_q <= 1'b0;
            if (fwd_now) begin
                mem_r_data <= fwd_val;
                r_valid_q  <= 1'b1;
            end else if (rd_acc) begin
                rd_pend <= 1'b1;
                rd_addr <= mem_r_addr;
            end

            case (state)
                ST_IDLE: begin
                    // A pending read jumps ahead of buffered writes unless one aliases it.
                    if (rd_pend && !hazard) begin
                        state     <= ST_RD_REQ;
                        rd_pend   <= 1'b0;
                        ext_req_q <= 1'b1;
                        ext_we    <= 1'b0;
                        ext_addr  <= rd_addr;
                    end else if (!empty && !(rd_acc && !fwd_now)) begin
                        state     <= ST_DRAIN;
                        ext_req_q <= 1'b1;
                        ext_we    <= 1'b1;
                        ext_addr  <= head_addr;
                        ext_wdata <= head_data;
                    end
                end
                ST_DRAIN: begin
                    if (ext_gnt) begin
                        state     <= ST_IDLE;
                        ext_req_q <= 1'b0;
                        ext_we    <= 1'b0;
                    end
                end
                ST_RD_REQ: begin
                    if (ext_gnt) begin
                        ext_req_q <= 1'b0;
                        if (ext_rvalid) begin
                            mem_r_data <= ext_rdata;
                            r_valid_q  <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (ext_rvalid) begin
                        mem_r_data <= ext_rdata;
                        r_valid_q  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bb_mem_bridge.sv
// Directed bench for bb_mem_bridge: posted writes, back-pressure, read hazards,
// same-cycle write/read ordering and mid-read reset, against a small memory model.
module tb_bb_mem_bridge;

    logic        clk;
    logic        rst_n;
    logic        mem_r_en;
    logic [15:0] mem_r_addr;
    logic        mem_w_en;
    logic [15:0] mem_w_addr;
    logic [15:0] mem_w_data;
    logic [15:0] mem_r_data;
    logic        mem_r_valid;
    logic        mem_busy;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [15:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [15:0] ext_rdata;

    logic        rsp_en;
    logic        rsp_v = 1'b0;
    logic [15:0] rsp_d = '0;
    logic        man_rv;
    logic [15:0] man_rd;
    logic [15:0] mem_m [256];

    logic [32:0] log_q[$];
    int          log_cyc[$];
    int          n_rv = 0;
    logic [15:0] last_rd = '0;
    int          cyc = 0;

    int          n_vec = 0;
    int          n_bad = 0;

    assign ext_rvalid = rsp_v | man_rv;
    assign ext_rdata  = man_rv ? man_rd : rsp_d;

    bb_mem_bridge #(
        .DATA_WIDTH (16),
        .WBUF_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_r_en    (mem_r_en),
        .mem_r_addr  (mem_r_addr),
        .mem_w_en    (mem_w_en),
        .mem_w_addr  (mem_w_addr),
        .mem_w_data  (mem_w_data),
        .mem_r_data  (mem_r_data),
        .mem_r_valid (mem_r_valid),
        .mem_busy    (mem_busy),
        .ext_req     (ext_req),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_gnt     (ext_gnt),
        .ext_rvalid  (ext_rvalid),
        .ext_rdata   (ext_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory: writes land on grant, reads answer one cycle after grant.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rsp_v <= rsp_en && ext_req && ext_gnt && !ext_we;
        rsp_d <= mem_m[ext_addr[7:0]];
        if (ext_req && ext_gnt && ext_we)
            mem_m[ext_addr[7:0]] <= ext_wdata;
    end

    always @(negedge clk) begin
        if (ext_req && ext_gnt) begin
            log_q.push_back({ext_we, ext_addr, ext_we ? ext_wdata : 16'h0000});
            log_cyc.push_back(cyc);
        end
        if (mem_r_valid) begin
            n_rv    <= n_rv + 1;
            last_rd <= mem_r_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int lb;
        int rv0;
        int acc_cyc;
        int k;
        logic busy_seen;

        rst_n = 1'b1; mem_r_en = 1'b0; mem_r_addr = '0; mem_w_en = 1'b0;
        mem_w_addr = '0; mem_w_data = '0; ext_gnt = 1'b0; rsp_en = 1'b1;
        man_rv = 1'b0; man_rd = '0;

        // Reset state
        repeat (3) tick();
        #3;
        chk("rst_ext_req", 64'(ext_req), 64'(0));
        chk("rst_r_valid", 64'(mem_r_valid), 64'(0));
        chk("rst_busy", 64'(mem_busy), 64'(0));
        chk("rst_r_data", 64'(mem_r_data), 64'(0));
        tick();
        rst_n = 1'b0;
        tick();

        // Single posted write with grant held high
        ext_gnt = 1'b1;
        lb = log_q.size();
        mem_w_en = 1'b1; mem_w_addr = 16'h0010; mem_w_data = 16'h1234;
        #3 chk("a_busy_acc", 64'(mem_busy), 64'(0));
        tick();
        acc_cyc = cyc;
        mem_w_en = 1'b0;
        busy_seen = 1'b0;
        repeat (6) begin
            #3 if (mem_busy) busy_seen = 1'b1;
            tick();
        end
        chk("a_busy_hold", 64'(busy_seen), 64'(0));
        chk("a_nwr", 64'(log_q.size() - lb), 64'(1));
        chk("a_entry", 64'(log_q[lb]), 64'({1'b1, 16'h0010, 16'h1234}));
        chk("a_latency", 64'((log_cyc[lb] - acc_cyc) <= 2), 64'(1));

        // Fill the buffer with grant low, fifth write stalls
        ext_gnt = 1'b0;
        lb = log_q.size();
        for (int i = 0; i < 4; i++) begin
            mem_w_en = 1'b1;
            mem_w_addr = 16'(16'h0100 + i);
            mem_w_data = 16'(16'hA000 + i);
            #3 chk("b_busy_fill", 64'(mem_busy), 64'(0));
            tick();
        end
        mem_w_addr = 16'h0104; mem_w_data = 16'hA004;
        #3 chk("b_busy_full", 64'(mem_busy), 64'(1));
        tick();
        #3 chk("b_busy_hold", 64'(mem_busy), 64'(1));
        chk("b_no_drain", 64'(log_q.size() - lb), 64'(0));
        tick();
        ext_gnt = 1'b1;
        k = 0;
        while (k < 10) begin
            #3 if (!mem_busy) break;
            tick();
            k++;
        end
        chk("b_accept5", 64'(mem_busy), 64'(0));
        tick();
        mem_w_en = 1'b0;
        repeat (20) tick();
        chk("b_nwr", 64'(log_q.size() - lb), 64'(5));
        for (int i = 0; i < 5; i++)
            chk("b_order", 64'(log_q[lb + i]), 64'({1'b1, 16'(16'h0100 + i), 16'(16'hA000 + i)}));

        // Read aliasing two buffered writes to the same address
        ext_gnt = 1'b0;
        lb = log_q.size();
        rv0 = n_rv;
        mem_w_en = 1'b1; mem_w_addr = 16'h0020; mem_w_data = 16'hAAAA;
        tick();
        mem_w_data = 16'hBBBB;
        tick();
        mem_w_en = 1'b0;
        mem_r_en = 1'b1; mem_r_addr = 16'h0020;
        #3 chk("c_rd_acc", 64'(mem_busy), 64'(0));
        tick();
        mem_r_en = 1'b0;
        #3;
`ifdef BB_BRIDGE_FWD_EN
        chk("c_fwd_valid", 64'(mem_r_valid), 64'(1));
        chk("c_fwd_data", 64'(mem_r_data), 64'(16'hBBBB));
`else
        chk("c_wait_busy", 64'(mem_busy), 64'(1));
`endif
        tick();
        ext_gnt = 1'b1;
        repeat (20) tick();
        chk("c_nrv", 64'(n_rv - rv0), 64'(1));
        chk("c_rdata", 64'(last_rd), 64'(16'hBBBB));
        chk("c_w0", 64'(log_q[lb]), 64'({1'b1, 16'h0020, 16'hAAAA}));
        chk("c_w1", 64'(log_q[lb + 1]), 64'({1'b1, 16'h0020, 16'hBBBB}));
`ifdef BB_BRIDGE_FWD_EN
        chk("c_nlog", 64'(log_q.size() - lb), 64'(2));
`else
        chk("c_nlog", 64'(log_q.size() - lb), 64'(3));
        chk("c_rd", 64'(log_q[lb + 2]), 64'({1'b0, 16'h0020, 16'h0000}));
`endif

        // Same-cycle write and read to one address
        lb = log_q.size();
        rv0 = n_rv;
        mem_w_en = 1'b1; mem_w_addr = 16'h0030; mem_w_data = 16'h5555;
        mem_r_en = 1'b1; mem_r_addr = 16'h0030;
        #3 chk("d_acc", 64'(mem_busy), 64'(0));
        tick();
        mem_w_en = 1'b0; mem_r_en = 1'b0;
        repeat (15) tick();
        chk("d_nrv", 64'(n_rv - rv0), 64'(1));
        chk("d_rdata", 64'(last_rd), 64'(16'h5555));
        chk("d_w", 64'(log_q[lb]), 64'({1'b1, 16'h0030, 16'h5555}));
`ifdef BB_BRIDGE_FWD_EN
        chk("d_nlog", 64'(log_q.size() - lb), 64'(1));
`else
        chk("d_nlog", 64'(log_q.size() - lb), 64'(2));
`endif

        // Read overtakes a buffered write, then reset lands in RD_WAIT
        ext_gnt = 1'b0;
        rsp_en = 1'b0;
        mem_w_en = 1'b1; mem_w_addr = 16'h0050; mem_w_data = 16'h7777;
        tick();
        mem_w_addr = 16'h0051; mem_w_data = 16'h8888;
        tick();
        mem_w_en = 1'b0;
        mem_r_en = 1'b1; mem_r_addr = 16'h0040;
        #3 chk("e_rd_acc", 64'(mem_busy), 64'(0));
        tick();
        mem_r_en = 1'b0;
        lb = log_q.size();
        rv0 = n_rv;
        ext_gnt = 1'b1;
        repeat (3) tick();
        #3;
        chk("e_wait_req", 64'(ext_req), 64'(0));
        chk("e_wait_busy", 64'(mem_busy), 64'(1));
        chk("e_nlog", 64'(log_q.size() - lb), 64'(2));
        chk("e_w0", 64'(log_q[lb]), 64'({1'b1, 16'h0050, 16'h7777}));
        chk("e_rd_first", 64'(log_q[lb + 1]), 64'({1'b0, 16'h0040, 16'h0000}));
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        man_rv = 1'b1; man_rd = 16'hDEAD;
        tick();
        man_rv = 1'b0;
        repeat (6) tick();
        #3;
        chk("e_no_valid", 64'(n_rv - rv0), 64'(0));
        chk("e_discard", 64'(log_q.size() - lb), 64'(2));
        chk("e_busy", 64'(mem_busy), 64'(0));
        chk("e_ext_req", 64'(ext_req), 64'(0));
        chk("e_r_data", 64'(mem_r_data), 64'(0));

        // Bridge is usable again after the reset
        rsp_en = 1'b1;
        tick();
        rv0 = n_rv;
        mem_r_en = 1'b1; mem_r_addr = 16'h0010;
        tick();
        mem_r_en = 1'b0;
        repeat (8) tick();
        chk("e_post_nrv", 64'(n_rv - rv0), 64'(1));
        chk("e_post_rdata", 64'(last_rd), 64'(16'h1234));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
